// File: rtl/fcn_pkg.sv
// Shared types for the FCN coprocessor: data width, signed activation type
// and the array sequencer state encoding.
package fcn_pkg;

    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] fcn_data_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } fcn_seq_state_e;

endpackage

// File: rtl/fcn_array_sequencer.sv
// Clears the systolic array, feeds one activation vector, flushes the skew
// and drains SIZE results. Define FCN_RELU_EN to clamp negative results to 0.
module fcn_array_sequencer
    import fcn_pkg::*;
#(
    parameter int SIZE    = 100,
    parameter int MAX_LEN = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_W-1:0]     in_data,
    input  logic                         in_last,
    output logic                         arr_rst_n,
    output logic signed [DATA_W-1:0]     arr_in,
    output logic                         feed_vld,
    output logic [$clog2(MAX_LEN)-1:0]   feed_idx,
    input  logic [SIZE*DATA_W-1:0]       arr_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_W-1:0]     out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         len_err
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = $clog2(SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SIZE - 2);
    localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(SIZE - 1);

    fcn_seq_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;
    logic             arr_rst_n_q;
    logic             len_err_q;
    logic             accept;
    logic             vec_end;
    fcn_data_t        cols [SIZE];

    assign accept  = in_ready_q && in_valid;
    assign vec_end = accept && (in_last || feed_idx == IDX_LAST);

    // cnt times the flush in FLUSH and then serves as out_idx in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            feed_idx    <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            arr_rst_n_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            arr_rst_n_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state       <= CLEAR;
                        busy_q      <= 1'b1;
                        arr_rst_n_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    state      <= FEED;
                    in_ready_q <= 1'b1;
                    feed_idx   <= '0;
                    len_err_q  <= 1'b0;
                end
                FEED: begin
                    if (vec_end) begin
                        state      <= FLUSH;
                        in_ready_q <= 1'b0;
                        cnt        <= '0;
                        len_err_q  <= !in_last;
                    end else if (accept) begin
                        feed_idx <= feed_idx + 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state       <= DRAIN;
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (cnt == OUT_LAST) begin
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < SIZE; c++) begin : g_cols
        assign cols[c] = fcn_data_t'(arr_out[c*DATA_W +: DATA_W]);
    end

    // Bubbles drive zero so the array accumulates nothing on idle cycles.
    assign arr_in    = accept ? in_data : '0;
    assign feed_vld  = accept;
    assign in_ready  = in_ready_q;
    assign arr_rst_n = arr_rst_n_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (cnt == OUT_LAST);
    assign busy      = busy_q;
    assign len_err   = len_err_q;

    always_comb begin
        out_data = '0;
        if (out_valid_q) begin
`ifdef FCN_RELU_EN
            out_data = cols[cnt][DATA_W-1] ? '0 : cols[cnt];
`else
            out_data = cols[cnt];
`endif
        end
    end

endmodule

// File: tb/tb_fcn_array_sequencer.sv
// Scoreboard bench for fcn_array_sequencer with a behavioural systolic array
// model; expected sums are computed directly as dot products of vector and weights.
module tb_fcn_array_sequencer;

    localparam int SIZE    = 4;
    localparam int MAX_LEN = 4;
    localparam int IDX_W   = $clog2(MAX_LEN);

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [31:0]        in_data;
    logic                      in_last;
    logic                      arr_rst_n;
    logic signed [31:0]        arr_in;
    logic                      feed_vld;
    logic [IDX_W-1:0]          feed_idx;
    logic [SIZE*32-1:0]        arr_out = '0;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [31:0]        out_data;
    logic                      out_last;
    logic                      busy;
    logic                      len_err;

    fcn_array_sequencer #(.SIZE(SIZE), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .arr_rst_n (arr_rst_n),
        .arr_in    (arr_in),
        .feed_vld  (feed_vld),
        .feed_idx  (feed_idx),
        .arr_out   (arr_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
        bit lerr;
    } exp_t;

    exp_t exp_q [$];
    int   rise_q [$];
    int   vec [$];
    int   wgt [SIZE][MAX_LEN];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   rdy_mode   = 0;
    int   rdy_phase  = 0;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string name, input longint act, input longint req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic flagTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait expired, required event never seen (cycle %0d)", name, cycle);
    endtask

    always @(posedge clk) cycle++;

    // Behavioural array: column c sees the feed stream delayed by c cycles
    // and accumulates data times the weight for the element index it carries.
    logic s_rst = 1'b0;
    int   s_in  = 0;
    int   s_idx = 0;
    int   fidx  = 0;
    int   acc   [SIZE];
    int   dly_d [SIZE];
    int   dly_i [SIZE];

    initial begin
        for (int c = 0; c < SIZE; c++) begin
            acc[c] = 0; dly_d[c] = 0; dly_i[c] = 0;
        end
    end

    // Snapshot the feed side away from the edge, and check the feed index
    // counts 0,1,2.. only on cycles that carry a real element.
    always @(negedge clk) begin
        s_rst = arr_rst_n;
        s_in  = int'(arr_in);
        s_idx = int'(feed_idx);
        if (!arr_rst_n) begin
            fidx = 0;
        end else if (feed_vld) begin
            checkOutput("feed_idx", feed_idx, fidx);
            fidx++;
        end else begin
            checkOutput("arr_in_bubble", arr_in, 0);
        end
    end

    // Array update at the edge, using the values captured at the negedge.
    always @(posedge clk) begin
        int d, ix;
        if (!s_rst) begin
            for (int c = 0; c < SIZE; c++) begin
                acc[c] = 0; dly_d[c] = 0; dly_i[c] = 0;
            end
        end else begin
            for (int c = 0; c < SIZE; c++) begin
                d  = (c == 0) ? s_in  : dly_d[c];
                ix = (c == 0) ? s_idx : dly_i[c];
                acc[c] += d * wgt[c][ix];
            end
            for (int c = SIZE - 1; c > 1; c--) begin
                dly_d[c] = dly_d[c-1];
                dly_i[c] = dly_i[c-1];
            end
            dly_d[1] = s_in;
            dly_i[1] = s_idx;
        end
        for (int c = 0; c < SIZE; c++) arr_out[c*32 +: 32] = acc[c];
    end

    // Downstream ready generator: always ready, 1,0,0,1 pattern, or random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (rdy_phase == 0 || rdy_phase == 3);
                    rdy_phase = (rdy_phase + 1) % 4;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: checks first-valid timing, hold while stalled, and pops the
    // scoreboard on every output handshake.
    bit prev_valid   = 1'b0;
    bit prev_stalled = 1'b0;
    bit prev_last_hs = 1'b0;
    int held_data    = 0;
    bit held_last    = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid   = 1'b0;
            prev_stalled = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_last_hs) checkOutput("busy_after_last", busy, 0);
            prev_last_hs = 1'b0;
            if (out_valid && !prev_valid) begin
                checkOutput("rise_expected", rise_q.size() > 0, 1);
                if (rise_q.size() > 0) checkOutput("first_valid_cycle", cycle, rise_q.pop_front());
            end
            if (out_valid && prev_stalled) begin
                checkOutput("hold_data", out_data, held_data);
                checkOutput("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                checkOutput("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_last", out_last, e.last);
                    checkOutput("busy_in_drain", busy, 1);
                    if (e.last) begin
                        checkOutput("len_err", len_err, e.lerr);
                        prev_last_hs = 1'b1;
                    end
                end
            end
            prev_valid   = out_valid;
            prev_stalled = out_valid && !out_ready;
            held_data    = int'(out_data);
            held_last    = out_last;
        end
    end

    task automatic setWeights(input bit rnd, input int val);
        for (int c = 0; c < SIZE; c++)
            for (int k = 0; k < MAX_LEN; k++)
                wgt[c][k] = rnd ? (int'($urandom_range(0, 15)) - 8) : val;
    endtask

    // Drives the vector in 'vec'; pushes expected results when expect_out is set.
    // Vectors longer than MAX_LEN go out without in_last and the excess element
    // must stall.
    task automatic applyStimulus(input bit expect_out, input int bub_min, input int bub_max);
        int   n_acc;
        bit   trunc;
        int   guard;
        bit   accepted;
        int   sum;
        exp_t e;
        trunc = vec.size() > MAX_LEN;
        n_acc = trunc ? MAX_LEN : vec.size();
        if (expect_out) begin
            for (int c = 0; c < SIZE; c++) begin
                sum = 0;
                for (int k = 0; k < n_acc; k++) sum += vec[k] * wgt[c][k];
`ifdef FCN_RELU_EN
                if (sum < 0) sum = 0;
`endif
                e.data = sum;
                e.last = (c == SIZE - 1);
                e.lerr = trunc;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < vec.size(); i++) begin
            if (i >= MAX_LEN) begin
                in_valid = 1'b1; in_data = vec[i]; in_last = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("excess_stalled", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
                break;
            end
            if (i > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(bub_min, bub_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = (i == vec.size() - 1);
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 50) begin
                @(negedge clk);
                if (in_ready) begin
                    accepted = 1'b1;
                    if (i == n_acc - 1 && expect_out) rise_q.push_back(cycle + SIZE);
                end
                guard++;
                @(posedge clk);
                #1;
            end
            if (!accepted) begin
                flagTimeout("input_handshake");
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) flagTimeout("wait_idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        setWeights(1'b0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_arr_rst_n", arr_rst_n, 0);
        checkOutput("rst_arr_in", arr_in, 0);
        checkOutput("rst_feed_vld", feed_vld, 0);
        checkOutput("rst_feed_idx", feed_idx, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_len_err", len_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_arr_rst_n", arr_rst_n, 1);
        checkOutput("idle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;

        $display("[TB] basic vector");
        vec = '{1, 2, 3};
        applyStimulus(1'b1, 0, 0);
        waitIdle(200);

        $display("[TB] bubbles");
        applyStimulus(1'b1, 2, 2);
        waitIdle(200);

        $display("[TB] truncation");
        vec = '{1, 2, 3, 4, 5};
        applyStimulus(1'b1, 0, 0);
        waitIdle(200);
        checkOutput("len_err_sticky", len_err, 1);

        $display("[TB] backpressure");
        rdy_mode = 1; rdy_phase = 0;
        vec = '{1, 2, 3};
        applyStimulus(1'b1, 0, 0);
        waitIdle(200);
        rdy_mode = 0;

        $display("[TB] reset during flush");
        setWeights(1'b0, 3);
        vec = '{7, 8};
        applyStimulus(1'b0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_arr_rst_n", arr_rst_n, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        setWeights(1'b0, 2);
        vec = '{5};
        applyStimulus(1'b1, 0, 0);
        waitIdle(200);

        $display("[TB] negative weights");
        setWeights(1'b0, -1);
        vec = '{4};
        applyStimulus(1'b1, 0, 0);
        waitIdle(200);

        $display("[TB] random vectors");
        for (int v = 0; v < 25; v++) begin
            int len;
            rdy_mode = $urandom_range(0, 2);
            setWeights(1'b1, 0);
            len = $urandom_range(1, MAX_LEN + 1);
            vec.delete();
            for (int k = 0; k < len; k++) vec.push_back(int'($urandom_range(0, 200)) - 100);
            applyStimulus(1'b1, 0, 2);
            waitIdle(300);
        end

        rdy_mode = 0;
        repeat (5) @(posedge clk);
        checkOutput("pending_outputs", exp_q.size(), 0);
        checkOutput("pending_rises", rise_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, compared %0d", compared);
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/fcn_array_sequencer.md
# fcn_array_sequencer

Control-side partner of the FCN coprocessor's systolic accumulator array. It clears the array, then streams one input-activation vector into column 0 with a valid/ready handshake. It waits out the column skew, then drains the SIZE accumulated neuron results as a serial valid/ready stream. Per-column weights are supplied outside this block, from `feed_idx`.

## Interface
- `SIZE`, default 100: number of array columns (neurons); must be ≥ 2.
- `MAX_LEN`, default 128: maximum input-vector length; must be ≥ 2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input element valid.
- `in_ready` out 1: block accepts an input element.
- `in_data` in 32 signed: input activation.
- `in_last` in 1: final element of the vector.
- `arr_rst_n` out 1: drives array reset; low clears the accumulators.
- `arr_in` out 32 signed: drives array `input_weight`.
- `feed_vld` out 1: `arr_in` carries a real element this cycle.
- `feed_idx` out clog2(MAX_LEN): element index on `arr_in`; weight source uses it, delayed by c cycles for column c.
- `arr_out` in SIZE×32 signed: array accumulator outputs.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts a result.
- `out_data` out 32 signed: result for neuron `out_idx`.
- `out_last` out 1: result for neuron SIZE-1.
- `busy` out 1: state ≠ IDLE.
- `len_err` out 1: sticky; set when a vector is truncated at MAX_LEN.

## Operation
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN.
- IDLE
  - `in_ready`=0.
  - `in_valid`=1 → CLEAR.
- CLEAR
  - Lasts exactly 1 cycle.
  - `arr_rst_n`=0, `in_ready`=0, `feed_idx`←0, then → FEED.
  - `len_err` is cleared here.
- FEED
  - `in_ready`=1.
  - On handshake: `arr_in`=`in_data`, `feed_vld`=1. `feed_idx` increments after each handshake.
  - No handshake (bubble): `arr_in`=0, `feed_vld`=0, `feed_idx` holds. Zero contributes nothing to any column, so bubbles are legal anywhere.
  - Handshake with `in_last`=1 → FLUSH.
  - Handshake at `feed_idx`=MAX_LEN-1 without `in_last`: element is treated as last, `len_err`←1, → FLUSH.
  - Excess input elements are not the block's concern. They stall at `in_ready`=0 until the next vector.
- FLUSH
  - `arr_in`=0, `feed_vld`=0, `in_ready`=0.
  - Counter runs SIZE-1 cycles, then → DRAIN with `out_idx`=0.
  - Flushing lets the last element reach column SIZE-1.
- DRAIN
  - `arr_in`=0, so accumulators hold.
  - `out_valid`=1.
  - `out_data` = `arr_out[out_idx]`, combinational mux; `arr_out` is stable throughout DRAIN.
  - `out_last` = (`out_idx`==SIZE-1).
  - Each `out_valid`&&`out_ready` increments `out_idx`.
  - Handshake with `out_last` → IDLE.
- `arr_rst_n`=1 in every state except CLEAR and reset.
- Reset is accepted in any state, mid-feed or mid-drain. It returns the FSM to IDLE and discards the partial vector.

## Timing
- Reset values:
  - `in_ready`=0, `arr_rst_n`=0, `arr_in`=0, `feed_vld`=0, `feed_idx`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `len_err`=0.
- `arr_in`, `feed_vld` and `feed_idx` are combinational from `in_data`/handshake in FEED. The array registers the element at that same edge.
- Input side:
  - First `in_valid` at cycle t (IDLE) → CLEAR at t+1.
  - First acceptance possible at t+2.
- Output side:
  - `in_last` accepted at edge T → FLUSH during T+1 … T+SIZE-1.
  - `out_valid` first high at T+SIZE.
- With `out_ready` held high, DRAIN lasts SIZE cycles; `busy` falls the cycle after the last output handshake.
- `out_data` holds stable while `out_valid`&&!`out_ready`.

## Configuration
- `FCN_RELU_EN` defined: `out_data` = `arr_out[out_idx]` if non-negative, else 0.
- `FCN_RELU_EN` undefined: `out_data` passes the raw signed accumulator.
- Handshake timing is identical in both builds.

## Structure
- Shared package `fcn_pkg` holds:
  - `DATA_W`=32.
  - `typedef signed [DATA_W-1:0] fcn_data_t`.
  - The FSM state enum `fcn_seq_state_e`.
- No sub-module. FSM, the feed/flush counter and the drain mux fit in one module.
- The array is instantiated beside this block at the coprocessor level.

## Test plan
- Basic vector: SIZE=4, all weights 1, input [1,2,3] with `in_last` on 3 → outputs 6,6,6,6 with `out_last` on the fourth. `out_valid` rises exactly SIZE cycles after the `in_last` edge.
- Bubbles: same vector, `in_valid` low for 2 cycles between elements → identical outputs. `feed_idx` reads 0,1,2 only on `feed_vld` cycles.
- Backpressure: `out_ready` toggles 1,0,0,1 … → each `out_data` held while stalled. Outputs arrive in neuron order 0..3 and `busy` stays high until the last handshake.
- Truncation: MAX_LEN=4, five elements sent with no `in_last` → fourth element ends the vector, `len_err`=1. `len_err` clears in the next CLEAR.
- Mid-operation reset: `rst_n` low during FLUSH, then a new vector [5] with weights 2 → all outputs 10. No residue from the aborted vector.
- ReLU build: `FCN_RELU_EN` defined, weights -1, input [4] → all outputs 0. Without the macro → all outputs -4.
